// File: rtl/fp_pkg.sv
// Shared fp32/fp16 constants, flag positions and operand classification.
package fp_pkg;

   localparam int FP32_BIAS = 127;
   localparam int FP16_BIAS = 15;

   // Flag vector bit positions (out_flags / sticky_flags)
   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_INX = 0;

   localparam logic [15:0] FP16_QNAN = 16'h7E00;
   localparam logic [15:0] FP16_INF  = 16'h7C00;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      SUB  = 3'd1,
      NORM = 3'd2,
      INF  = 3'd3,
      NAN  = 3'd4
   } fp_class_e;

   // Decoded fp32 operand held in stage S1
   typedef struct packed {
      logic              sign;
      fp_class_e         cls;
      logic signed [9:0] expo;   // fp32 exponent rebiased to fp16
      logic [23:0]       sig;    // significand with hidden bit
   } s1_word_t;

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational denormalise / round-to-nearest-even / pack into binary16.
// Input is a classified operand with an exponent already rebiased to fp16.
module fp16_round_pack
   import fp_pkg::*;
#(
   parameter bit FLUSH_SUBNORMAL = 1'b0
) (
   input  logic              sign,
   input  fp_class_e         cls,
   input  logic signed [9:0] expo,
   input  logic [23:0]       sig,
   output logic [15:0]       data,
   output logic [3:0]        flags
);

   logic signed [9:0] shamt;
   logic [47:0]       shifted;
   logic [23:0]       sig_dn;
   logic              lost;
   logic [9:0]        man;
   logic              guard;
   logic              sticky;
   logic              rnd;
   logic              tiny;
   logic [4:0]        efield;
   logic [14:0]       sum;
   logic              inexact;

   // Denormalise tiny values, then round the 10-bit mantissa with RNE
   always_comb begin
      shamt   = 10'sd1 - expo;
      tiny    = (expo <= 10'sd0);
      shifted = '0;
      sig_dn  = sig;
      lost    = 1'b0;
      if (tiny) begin
         if (shamt >= 10'sd25) begin
            // Everything shifts past the guard bit: only sticky survives
            sig_dn = '0;
            lost   = |sig;
         end else begin
            shifted = {sig, 24'd0} >> shamt[4:0];
            sig_dn  = shifted[47:24];
            lost    = |shifted[23:0];
         end
      end
      man     = sig_dn[22:13];
      guard   = sig_dn[12];
      sticky  = (|sig_dn[11:0]) | lost;
      rnd     = guard & (sticky | man[0]);
      inexact = guard | sticky;
      // After a right shift the hidden bit is 0, which is the subnormal field
      efield  = tiny ? {4'd0, sig_dn[23]} : expo[4:0];
      // A mantissa carry ripples into the exponent field for free
      sum     = {efield, man} + 15'(rnd);
   end

   // Select the packed result and flags by operand class
   always_comb begin
      data  = {sign, 15'd0};
      flags = '0;
      case (cls)
         ZERO: begin
            data = {sign, 15'd0};
         end
         SUB: begin
            data           = {sign, 15'd0};
            flags[FLG_UNF] = 1'b1;
            flags[FLG_INX] = 1'b1;
         end
         INF: begin
            data = FP16_INF | {sign, 15'd0};
         end
         NAN: begin
            data           = FP16_QNAN | {sign, 15'd0};
            flags[FLG_INV] = ~sig[22];
         end
         default: begin
            if (expo >= 10'sd31) begin
               data           = FP16_INF | {sign, 15'd0};
               flags[FLG_OVF] = 1'b1;
               flags[FLG_INX] = 1'b1;
            end else if (FLUSH_SUBNORMAL && tiny && (sum[14:10] == 5'd0)) begin
               data           = {sign, 15'd0};
               flags[FLG_UNF] = 1'b1;
               flags[FLG_INX] = 1'b1;
            end else begin
               // Rounding up to exponent 31 packs exactly as infinity
               data           = {sign, sum};
               flags[FLG_OVF] = (sum[14:10] == 5'd31);
               flags[FLG_INX] = inexact;
               // Tiny means still subnormal after rounding (0x387FE000 -> 0x0400 is not)
               flags[FLG_UNF] = tiny & inexact & (sum[14:10] == 5'd0);
            end
         end
      endcase
   end

endmodule

// File: rtl/fp32_to_fp16_conv.sv
// Two-stage fp32 -> fp16 converter with valid/ready on both sides.
// S1 classifies and rebiases, S2 rounds/packs into the output register.
module fp32_to_fp16_conv
   import fp_pkg::*;
#(
   parameter bit FLUSH_SUBNORMAL = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic [3:0]  out_flags,
   output logic [3:0]  sticky_flags,
   input  logic        flag_clr
);

   localparam logic signed [9:0] REBIAS = 10'(FP32_BIAS - FP16_BIAS);

   s1_word_t    s1_d;
   s1_word_t    s1_q;
   logic        s1_valid;
   logic        s1_advance;
   logic        s2_load;
   logic [7:0]  e32;
   logic [22:0] m32;
   logic [15:0] rp_data;
   logic [3:0]  rp_flags;

   assign e32 = in_data[30:23];
   assign m32 = in_data[22:0];

   // Flow control: in_ready depends combinationally on out_ready
   assign s2_load    = ~out_valid | out_ready;
   assign s1_advance = s2_load;
   assign in_ready   = ~s1_valid | s1_advance;

   // Classify the incoming fp32 word and rebias its exponent
   always_comb begin
      s1_d.sign = in_data[31];
      s1_d.sig  = {|e32, m32};
      s1_d.expo = $signed({2'b00, e32}) - REBIAS;
      if (e32 == 8'd0)
         s1_d.cls = (m32 == '0) ? ZERO : SUB;
      else if (e32 == 8'hFF)
         s1_d.cls = (m32 == '0) ? INF : NAN;
      else
         s1_d.cls = NORM;
   end

   // Stage S1 register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) s1_q <= s1_d;
      end
   end

   fp16_round_pack #(
      .FLUSH_SUBNORMAL (FLUSH_SUBNORMAL)
   ) u_round_pack (
      .sign  (s1_q.sign),
      .cls   (s1_q.cls),
      .expo  (s1_q.expo),
      .sig   (s1_q.sig),
      .data  (rp_data),
      .flags (rp_flags)
   );

   // Stage S2 output register; holds steady while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_flags <= '0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data  <= rp_data;
            out_flags <= rp_flags;
         end
      end
   end

   // Sticky flags: accumulate on output handshake, set wins over clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sticky_flags <= '0;
      else if (out_valid && out_ready)
         sticky_flags <= (flag_clr ? 4'd0 : sticky_flags) | out_flags;
      else if (flag_clr)
         sticky_flags <= '0;
   end

endmodule

// File: tb/tb_fp32_to_fp16_conv.sv
// Scoreboard bench for fp32_to_fp16_conv: directed vectors, backpressure,
// reset, sticky flags and randomized words against an arithmetic model.
module tb_fp32_to_fp16_conv;

   localparam bit FLUSH = 1'b0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [3:0]  out_flags;
   logic [3:0]  sticky_flags;
   logic        flag_clr = 1'b0;

   typedef struct {
      logic [15:0] d;
      logic [3:0]  f;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          accepted = 0;
   bit          rand_phase = 1'b0;
   logic [3:0]  exp_sticky = '0;
   bit          held_v = 1'b0;
   logic [19:0] held = '0;

   fp32_to_fp16_conv #(.FLUSH_SUBNORMAL(FLUSH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_flags    (out_flags),
      .sticky_flags (sticky_flags),
      .flag_clr     (flag_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: value = sig * 2^(e-150); quantise to the fp16 step of its binade
   function automatic void ref_conv(input logic [31:0] x, output logic [15:0] d,
                                    output logic [3:0] f);
      int     e, u, ue, sh;
      longint sig, n, rem, half, bits;
      logic   s;
      s = x[31];
      e = int'(x[30:23]);
      f = 4'b0000;
      if (e == 255) begin
         if (x[22:0] == 23'd0) d = {s, 15'h7C00};
         else begin
            d = {s, 15'h7E00};
            f[3] = ~x[22];
         end
         return;
      end
      if (e == 0) begin
         d = {s, 15'h0000};
         if (x[22:0] != 23'd0) f = 4'b0011;
         return;
      end
      sig = longint'({1'b1, x[22:0]});
      u   = e - 127;
      ue  = (u < -14) ? -14 : u;
      sh  = (ue - 10) - (e - 150);
      if (sh >= 40) begin
         n = 0; rem = sig; half = longint'(1) << 45;
      end else begin
         n = sig >> sh; rem = sig - (n << sh); half = longint'(1) << (sh - 1);
      end
      if (rem > half || (rem == half && n[0])) n++;
      bits = (longint'(ue + 14) << 10) + n;
      if (rem != 0) f[0] = 1'b1;
      if (bits >= 64'h7C00) begin
         d = {s, 15'h7C00};
         f = 4'b0101;
      end else if (FLUSH && bits < 64'h400) begin
         d = {s, 15'h0000};
         f = 4'b0011;
      end else begin
         d = {s, bits[14:0]};
         if (bits < 64'h400 && rem != 0) f[1] = 1'b1;
      end
   endfunction

   task automatic send(input logic [31:0] x, input logic [15:0] d, input logic [3:0] f);
      int   w;
      exp_t e;
      w = 0;
      in_valid = 1'b1;
      in_data  = x;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("send_accept", {31'd0, in_ready}, 32'd1);
      if (in_ready) begin
         e.d = d; e.f = f;
         sb.push_back(e);
         accepted++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_model(input logic [31:0] x);
      logic [15:0] d;
      logic [3:0]  f;
      ref_conv(x, d, f);
      send(x, d, f);
   endtask

   task automatic drain(input string name);
      int w;
      w = 0;
      while (sb.size() != 0 && w < 500) begin
         @(posedge clk);
         w++;
      end
      #1;
      check(name, sb.size(), 32'd0);
   endtask

   function automatic logic [31:0] gen_word();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 5))
         0: ;
         1: r[30:23] = 8'($urandom_range(100, 145));
         2: r[30:23] = 8'($urandom_range(101, 113));
         3: begin
            r[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            if ($urandom_range(0, 2) == 0) r[22:0] = '0;
         end
         4: begin
            r[30:23] = 8'($urandom_range(100, 142));
            r[12:0]  = 13'h1000;
         end
         default: begin
            r[30:23] = 8'd142;
            r[22:12] = 11'h7FF;
         end
      endcase
      return r;
   endfunction

   // Monitor: pops the scoreboard on each output handshake, tracks sticky flags
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst_n) begin
         exp_sticky = '0;
         held_v = 1'b0;
      end else begin
         check("sticky", sticky_flags, exp_sticky);
         if (held_v) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {out_flags, out_data}, held);
         end
         held_v = out_valid && !out_ready;
         held   = {out_flags, out_data};
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output actual=%h required=none", out_data);
            end else begin
               e = sb.pop_front();
               check("data", out_data, e.d);
               check("flags", out_flags, e.f);
               exp_sticky = (flag_clr ? 4'd0 : exp_sticky) | e.f;
            end
         end else if (flag_clr) begin
            exp_sticky = '0;
         end
      end
   end

   // Random backpressure and flag clears during the random phase
   initial forever begin
      @(posedge clk);
      #1;
      if (rand_phase) begin
         out_ready = ($urandom_range(0, 3) != 0);
         flag_clr  = ($urandom_range(0, 15) == 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] vin [17] = '{32'h3F800000, 32'hC0000000, 32'h477FE000, 32'h477FF000,
                             32'h3F801000, 32'h3F803000, 32'h33800000, 32'h33000000,
                             32'h387FE000, 32'hFF800001, 32'h7FC00000, 32'hFF800000,
                             32'h80000000, 32'h00000000, 32'h80000001, 32'h7F800000,
                             32'h7F000000};
   logic [15:0] vd  [17] = '{16'h3C00, 16'hC000, 16'h7BFF, 16'h7C00,
                             16'h3C00, 16'h3C02, 16'h0001, 16'h0000,
                             16'h0400, 16'hFE00, 16'h7E00, 16'hFC00,
                             16'h8000, 16'h0000, 16'h8000, 16'h7C00,
                             16'h7C00};
   logic [3:0]  vf  [17] = '{4'h0, 4'h0, 4'h0, 4'h5,
                             4'h1, 4'h1, 4'h0, 4'h3,
                             4'h1, 4'h8, 4'h0, 4'h0,
                             4'h0, 4'h0, 4'h3, 4'h0,
                             4'h5};

   initial begin
      int w;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_flags", out_flags, 32'd0);
      check("rst_sticky", sticky_flags, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Latency: out_valid appears exactly two cycles after the handshake cycle
      out_ready = 1'b1;
      send(32'h3F800000, 16'h3C00, 4'h0);
      check("lat_cycle1", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      check("lat_cycle2", {31'd0, out_valid}, 32'd1);

      for (int i = 0; i < 17; i++) send(vin[i], vd[i], vf[i]);
      drain("drain_directed");

      // Backpressure: two words fill the pipe, remaining three wait
      out_ready = 1'b0;
      accepted  = 0;
      fork
         begin
            for (int i = 0; i < 5; i++) send_model(32'h3F800000 + i * 32'h00A01234);
         end
      join_none
      repeat (8) @(posedge clk);
      #1;
      check("bp_accepted", accepted, 32'd2);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      w = 0;
      while ((accepted < 5 || sb.size() != 0) && w < 100) begin
         @(posedge clk);
         w++;
      end
      #1;
      check("bp_drained", accepted, 32'd5);
      drain("drain_bp");

      // Sticky: set from an overflow wins over a coincident clear
      send(32'hFF800001, 16'hFE00, 4'h8);
      drain("drain_snan");
      out_ready = 1'b0;
      send(32'h477FF000, 16'h7C00, 4'h5);
      w = 0;
      while (!out_valid && w < 20) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("ovf_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      flag_clr  = 1'b1;
      @(posedge clk);
      #1;
      flag_clr  = 1'b0;
      check("sticky_set_wins", sticky_flags, 32'h5);

      // Mid-stream reset: pipeline contents are discarded
      out_ready = 1'b0;
      send_model(32'h40490FDB);
      send_model(32'h3EAAAAAB);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_sticky", sticky_flags, 32'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("midrst_no_stale", {31'd0, out_valid}, 32'd0);

      // Random words with random backpressure and flag clears
      rand_phase = 1'b1;
      for (int i = 0; i < 400; i++) begin
         int gap;
         send_model(gen_word());
         gap = $urandom_range(0, 2);
         if (gap != 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      rand_phase = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      flag_clr  = 1'b0;
      drain("drain_random");

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
